rvv_backend_decode_sched: RTL
=============================

Name: rvv_backend_decode_sched

Overview:
Parametrised uop issue scheduler between the decode units and the Uop Queue. It generalises the two-instruction, four-lane decode controller to NUM_INST decoded instructions and NUM_PUSH push lanes, and uses a free-slot count in place of per-level full flags. It tracks the split progress of the head instruction across cycles. It adds an optional mode that lets the last admitted instruction start issuing partially, plus a synchronous flush.

Parameters:
NUM_INST, 2, decoded instruction slots presented per cycle (slot 0 = oldest)
NUM_PUSH, 4, Uop Queue push lanes per cycle
MAX_UOP, 8, max uops per instruction
UOP_W, 64, uop payload width
CNT_W, $clog2(MAX_UOP+1), uop count width
FREE_W, $clog2(NUM_PUSH+1), free-count width
PARTIAL_NONHEAD, 0, 1 = a non-head instruction may begin partial issue

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
inst_valid  in  NUM_INST  slot holds a decoded instruction
inst_uop_cnt  in  NUM_INST*CNT_W  total uops of the slot's instruction (0..MAX_UOP)
inst_uop_data  in  NUM_INST*MAX_UOP*UOP_W  decoded uops, indexed by uop index
uq_free_cnt  in  FREE_W  free Uop Queue entries, saturated at NUM_PUSH
flush  in  1  discard in-progress split
pop  out  NUM_INST  instruction fully issued; pop is always a prefix (pop[i] implies pop[i-1])
push  out  NUM_PUSH  lane valid; always a prefix
push_data  out  NUM_PUSH*UOP_W  uop payload per lane
push_uop_index  out  NUM_PUSH*CNT_W  index of the uop within its instruction
uop_index_remain  out  CNT_W  registered index of the next uop of slot 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Only one state register: idx (uop_index_remain), the next uop of slot 0. Reset value 0.
- push, push_data, push_uop_index and pop are combinational from inputs and idx (0-cycle latency). idx updates on the clk edge.
- While rst_n=0: push=0, pop=0, push_data=0, push_uop_index=0.
- Effective valid: v[i] = inst_valid[i] AND v[i-1]. Slots beyond the first gap are ignored.
- cnt > MAX_UOP is an assertion error and is treated as MAX_UOP. Slot 0 with idx >= cnt is an assertion error.
- Lane budget: L = min(NUM_PUSH, uq_free_cnt). Lanes are filled in slot order, with no lane gaps.
- Slot 0: rem0 = cnt0 - idx; issues n0 = min(rem0, L).
  - Lanes 0..n0-1 carry data[0][idx+k], with index idx+k.
  - If n0 == rem0: pop[0]=1. Otherwise idx_next = idx + n0 and no other slot issues.
- Slot i>0 is considered only if all earlier slots popped, with R = remaining lanes:
  - cnt_i <= R: issue all cnt_i uops (index 0..cnt_i-1), pop[i]=1.
  - cnt_i > R, PARTIAL_NONHEAD=1, R>0: issue R uops (index 0..R-1), no pop[i], idx_next = R. Scanning stops. Slot i is slot 0 next cycle, once the command queue has shifted by the popped count.
  - Otherwise scanning stops.
- cnt == 0 (vl=0 or discarded instruction): pops without using a lane and does not stop scanning.
- idx_next = 0 whenever a pop occurs and no partial issue starts in that cycle.
- uq_free_cnt == 0, or v[0]=0: no push, no pop, idx holds.
- flush=1 (rst_n=1): push=0, pop=0, idx_next=0. Flush has lower priority than reset.
- Reset mid-split: idx returns to 0, so the instruction restarts from uop 0.
- Inputs are assumed stable while not popped. The command queue shifts by popcount(pop) on the edge.

Test Plan:
All scenarios use defaults unless stated (NUM_INST=2, NUM_PUSH=4, MAX_UOP=8).
- Split: slot0 cnt=8, free=4 each cycle. Cycle 1: push=4'b1111, indices 0-3, pop=0, idx becomes 4. Cycle 2: indices 4-7, pop=2'b01, idx becomes 0.
- Pair: slot0 cnt=2, slot1 cnt=2, free=4. Result: push=4'b1111, indices 0,1,0,1, pop=2'b11, idx stays 0.
- Non-fit, PARTIAL_NONHEAD=0: slot0 cnt=2, slot1 cnt=3, free=4. Result: push=4'b0011, pop=2'b01. Same stimulus with PARTIAL_NONHEAD=1: push=4'b1111 (slot1 indices 0,1), pop=2'b01, idx becomes 2. Next cycle (slot1 now slot0, cnt=3): push=4'b0001 with index 2, pop=2'b01.
- Backpressure: slot0 cnt=3, free=1 for 3 cycles, then 0 for 1 cycle. One uop per cycle at indices 0,1,2, pop on cycle 3. The free=0 cycle shows no activity.
- Flush/reset: with idx=4 after a split, assert flush for one cycle. Result: push=0, pop=0, and the next cycle issues from index 0. Repeat with rst_n=0 instead of flush: all outputs 0, idx=0.
- Zero count: slot0 cnt=0, slot1 cnt=4, free=4. Result: pop=2'b11, push=4'b1111 carrying slot1 indices 0-3. With inst_valid=2'b10, nothing issues.

Source files
------------

// File: rtl/rvv_backend_decode_sched.sv
// -----------------------------------------------------------------------------
// rvv_backend_decode_sched
//   Issue scheduler between the vector decode units and the Uop Queue.
//   Each cycle it looks at up to NUM_INST decoded instructions (slot 0 is the
//   oldest) and packs their uops into up to NUM_PUSH push lanes. The number of
//   lanes is limited by the free-entry count of the Uop Queue. An instruction
//   that does not fit is split across cycles; the uop index where the head
//   instruction resumes is the only piece of state.
//
// Ports
//   clk                 clock
//   rst_n               synchronous active-low reset
//   inst_valid_i        per-slot valid of the decoded instruction
//   inst_uop_cnt_i      per-slot total uop count (0..MAX_UOP)
//   inst_uop_data_i     per-slot uop payloads, indexed [slot][uop]
//   uq_free_cnt_i       free Uop Queue entries (saturated at NUM_PUSH)
//   flush_i             abandon any in-progress split
//   pop_o               slot fully issued (prefix)
//   push_o              lane valid (prefix)
//   push_data_o         per-lane uop payload
//   push_uop_index_o    per-lane uop index inside its instruction
//   uop_index_remain_o  next uop index of slot 0 (registered)
// -----------------------------------------------------------------------------

// Per-lane payload mux: picks uop idx_i of slot slot_i, zero when the lane is
// idle so unused lanes never carry stale data.
module rvv_backend_decode_sched_lane #(
    parameter int NUM_INST = 2,
    parameter int MAX_UOP  = 8,
    parameter int UOP_W    = 64,
    parameter int CNT_W    = 4,
    parameter int SLOT_W   = 1
) (
    input  logic                              vld_i,
    input  logic [SLOT_W-1:0]                 slot_i,
    input  logic [CNT_W-1:0]                  idx_i,
    input  logic [NUM_INST*MAX_UOP*UOP_W-1:0] data_i,
    output logic [UOP_W-1:0]                  data_o
);
    always_comb begin
        data_o = '0;
        if (vld_i && (int'(idx_i) < MAX_UOP) && (int'(slot_i) < NUM_INST))
            data_o = data_i[(int'(slot_i)*MAX_UOP + int'(idx_i))*UOP_W +: UOP_W];
    end
endmodule

module rvv_backend_decode_sched #(
    parameter int NUM_INST        = 2,
    parameter int NUM_PUSH        = 4,
    parameter int MAX_UOP         = 8,
    parameter int UOP_W           = 64,
    parameter int CNT_W           = $clog2(MAX_UOP+1),
    parameter int FREE_W          = $clog2(NUM_PUSH+1),
    parameter bit PARTIAL_NONHEAD = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_INST-1:0]               inst_valid_i,
    input  logic [NUM_INST*CNT_W-1:0]         inst_uop_cnt_i,
    input  logic [NUM_INST*MAX_UOP*UOP_W-1:0] inst_uop_data_i,
    input  logic [FREE_W-1:0]                 uq_free_cnt_i,
    input  logic                              flush_i,
    output logic [NUM_INST-1:0]               pop_o,
    output logic [NUM_PUSH-1:0]               push_o,
    output logic [NUM_PUSH*UOP_W-1:0]         push_data_o,
    output logic [NUM_PUSH*CNT_W-1:0]         push_uop_index_o,
    output logic [CNT_W-1:0]                  uop_index_remain_o
);
    localparam int SLOT_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;

    logic [CNT_W-1:0]                    idx_q, idx_d;
    logic [NUM_INST-1:0]                 v;
    logic [NUM_INST-1:0][CNT_W-1:0]      cnt;
    logic [NUM_INST-1:0]                 pop_c;
    logic [NUM_PUSH-1:0]                 lane_vld;
    logic [NUM_PUSH-1:0][SLOT_W-1:0]     lane_slot;
    logic [NUM_PUSH-1:0][CNT_W-1:0]      lane_idx;

    // Valid chain stops at the first empty slot; counts above MAX_UOP are
    // malformed and clamped so they cannot index past the payload array.
    always_comb begin
        v   = '0;
        cnt = '0;
        for (int i = 0; i < NUM_INST; i++) begin
            v[i] = inst_valid_i[i] & ((i == 0) ? 1'b1 : v[(i == 0) ? 0 : i-1]);
            if (int'(inst_uop_cnt_i[i*CNT_W +: CNT_W]) > MAX_UOP)
                cnt[i] = CNT_W'(MAX_UOP);
            else
                cnt[i] = inst_uop_cnt_i[i*CNT_W +: CNT_W];
        end
    end

    // Lane allocation. Slots are walked oldest first; each gets as many of the
    // remaining lanes as it needs. Scanning stops at the first slot that
    // cannot finish this cycle, after letting it start a partial issue if it
    // is the head (always) or PARTIAL_NONHEAD is set.
    int   budget;
    int   used;
    int   base;
    int   rem;
    int   room;
    int   take;
    logic stop;
    logic partial;

    always_comb begin
        pop_c     = '0;
        lane_vld  = '0;
        lane_slot = '0;
        lane_idx  = '0;
        idx_d     = idx_q;
        used      = 0;
        base      = 0;
        rem       = 0;
        room      = 0;
        take      = 0;
        stop      = 1'b0;
        partial   = 1'b0;
        budget    = (int'(uq_free_cnt_i) < NUM_PUSH) ? int'(uq_free_cnt_i) : NUM_PUSH;

        if (!rst_n || flush_i) begin
            idx_d = '0;
        end else if (budget != 0 && v[0]) begin
            for (int i = 0; i < NUM_INST; i++) begin
                if (v[i] && !stop) begin
                    base = (i == 0) ? int'(idx_q) : 0;
                    rem  = int'(cnt[i]) - base;
                    if (rem < 0)
                        rem = 0;
                    room = budget - used;
                    if (rem <= room) begin
                        // cnt==0 lands here with take=0: pops, no lane used
                        take     = rem;
                        pop_c[i] = 1'b1;
                    end else if (i == 0 || (PARTIAL_NONHEAD && room > 0)) begin
                        take    = room;
                        partial = 1'b1;
                        stop    = 1'b1;
                        idx_d   = CNT_W'(base + room);
                    end else begin
                        take = 0;
                        stop = 1'b1;
                    end
                    for (int k = 0; k < NUM_PUSH; k++) begin
                        if (k >= used && k < used + take) begin
                            lane_vld[k]  = 1'b1;
                            lane_slot[k] = SLOT_W'(i);
                            lane_idx[k]  = CNT_W'(base + k - used);
                        end
                    end
                    used = used + take;
                end
            end
            // A completed head with no new partial start resumes at uop 0
            if (!partial && pop_c != '0)
                idx_d = '0;
        end
    end

    for (genvar l = 0; l < NUM_PUSH; l++) begin : g_lane
        rvv_backend_decode_sched_lane #(
            .NUM_INST (NUM_INST),
            .MAX_UOP  (MAX_UOP),
            .UOP_W    (UOP_W),
            .CNT_W    (CNT_W),
            .SLOT_W   (SLOT_W)
        ) u_lane (
            .vld_i  (lane_vld[l]),
            .slot_i (lane_slot[l]),
            .idx_i  (lane_idx[l]),
            .data_i (inst_uop_data_i),
            .data_o (push_data_o[l*UOP_W +: UOP_W])
        );
        assign push_uop_index_o[l*CNT_W +: CNT_W] = lane_idx[l];
    end

    assign push_o             = lane_vld;
    assign pop_o              = pop_c;
    assign uop_index_remain_o = idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            idx_q <= '0;
        else
            idx_q <= idx_d;
    end
endmodule
